// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with glitch-free ratio change
//
// Purpose:
//   Generates a registered divided clock whose high and low phases each last
//   div_cur cycles of clk. A new ratio offered through a valid/ready handshake
//   is loaded directly while the divider is idle; while it is running, the
//   ratio is held in a shadow register and only applied at a falling toggle,
//   so no output phase is ever cut short.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rstn       in   synchronous active-low reset
//   enable     in   1 = run the divided clock, 0 = park it low
//   req_valid  in   a new half-period ratio is offered on req_div
//   req_div    in   requested half-period ratio (WIDTH bits)
//   req_ready  out  a request can be accepted this cycle
//   clk_out    out  registered divided clock
//   tick       out  one-cycle strobe on each clk_out rising transition
//   div_cur    out  half-period ratio currently in effect (WIDTH bits)
//   busy       out  a ratio change is pending
//   err        out  one-cycle strobe after a zero ratio request was accepted

module clk_div_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_div,
  output logic             req_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shd_q, shd_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             accept;
  logic             req_zero;
  logic             req_load;
  logic             term;

  assign accept   = req_valid & req_ready;
  assign req_zero = (req_div == '0);
  assign req_load = accept & ~req_zero;
  // div_q only changes together with a reload of cnt to 1, so cnt never
  // passes div_q; >= just keeps the compare safe against any upset.
  assign term     = (cnt_q >= div_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= ONE;
      div_q     <= DEF_DIV_W;
      shd_q     <= DEF_DIV_W;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shd_q     <= shd_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shd_d     = shd_q;
    clk_out_d = clk_out_q;
    // A zero ratio is dropped; only the strobe records it.
    err_d     = accept & req_zero;

    case (state_q)
      S_IDLE: begin
        clk_out_d = 1'b0;
        cnt_d     = ONE;
        // A ratio load keeps the divider parked for this cycle.
        if (req_load) begin
          div_d = req_div;
        end else if (enable) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!enable && !clk_out_q) begin
          // Parked low already: stop without finishing the low phase.
          state_d = S_IDLE;
          cnt_d   = ONE;
          if (req_load) begin
            div_d = req_div;
          end
        end else begin
          if (term) begin
            clk_out_d = ~clk_out_q;
            cnt_d     = ONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
          if (term && clk_out_q && !enable) begin
            // High phase finished while disabled: stop, and a ratio
            // arriving now can be taken directly since the output is parked.
            state_d = S_IDLE;
            if (req_load) begin
              div_d = req_div;
            end
          end else if (req_load) begin
            shd_d   = req_div;
            state_d = S_PEND;
          end
        end
      end

      S_PEND: begin
        if (!enable && !clk_out_q) begin
          state_d = S_IDLE;
          cnt_d   = ONE;
          div_d   = shd_q;
        end else if (term) begin
          clk_out_d = ~clk_out_q;
          cnt_d     = ONE;
          // Only the falling toggle is a safe point to switch ratios.
          if (clk_out_q) begin
            div_d   = shd_q;
            state_d = enable ? S_RUN : S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = ONE;
        clk_out_d = 1'b0;
      end
    endcase

    tick_d = clk_out_d & ~clk_out_q;
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q != S_PEND);
    busy      = (state_q == S_PEND);
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_cur = div_q;
  assign err     = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl

module tb_clk_div_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         enable;
  logic         req_valid;
  logic [W-1:0] req_div;
  logic         req_ready;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] div_cur;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_err    = 0;

  clk_div_ctrl #(.WIDTH(W), .DEF_DIV(1)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .req_valid(req_valid),
    .req_div  (req_div),
    .req_ready(req_ready),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference model: tracks whether the divider runs, whether a ratio is
  // waiting, the output level and how long the current phase has lasted.
  bit m_run, m_pend, m_lvl, m_tick, m_err;
  int m_age, m_div, m_shd;

  task automatic model_step();
    bit acc, load, prev, done, falling;
    if (!rstn) begin
      m_run = 0; m_pend = 0; m_lvl = 0; m_tick = 0; m_err = 0;
      m_age = 0; m_div = 1; m_shd = 1;
      return;
    end
    acc   = req_valid && !m_pend;
    load  = acc && (req_div != 0);
    m_err = acc && (req_div == 0);
    prev  = m_lvl;
    done  = (m_age + 1 >= m_div);
    if (!m_run) begin
      m_lvl = 0; m_age = 0;
      if (load) m_div = int'(req_div);
      else if (enable) m_run = 1;
    end else if (!enable && !m_lvl) begin
      m_run = 0; m_age = 0;
      if (m_pend) begin m_div = m_shd; m_pend = 0; end
      else if (load) m_div = int'(req_div);
    end else begin
      falling = done && m_lvl;
      if (done) begin m_lvl = !m_lvl; m_age = 0; end
      else m_age++;
      if (falling) begin
        if (m_pend) begin m_div = m_shd; m_pend = 0; end
        if (!enable) m_run = 0;
      end
      if (load) begin
        if (m_run) begin m_shd = int'(req_div); m_pend = 1; end
        else m_div = int'(req_div);
      end
    end
    m_tick = m_lvl && !prev;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit r, en, rv;
    int rd;
    bit e_clk, e_tick;
    int e_div;
    bit e_busy, e_rdy, e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit en, input bit rv, input int rd,
                     input bit c, input bit t, input int d,
                     input bit b, input bit y, input bit e);
    vec_t v;
    v.r = r; v.en = en; v.rv = rv; v.rd = rd;
    v.e_clk = c; v.e_tick = t; v.e_div = d; v.e_busy = b; v.e_rdy = y; v.e_err = e;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag, input bit c, input bit t, input int d,
                         input bit b, input bit y, input bit e);
    chk({tag, ".clk_out"}, int'(clk_out), int'(c));
    chk({tag, ".tick"}, int'(tick), int'(t));
    chk({tag, ".div_cur"}, int'(div_cur), d);
    chk({tag, ".busy"}, int'(busy), int'(b));
    chk({tag, ".req_ready"}, int'(req_ready), int'(y));
    chk({tag, ".err"}, int'(err), int'(e));
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; enable = 1'b0; req_valid = 1'b0; req_div = '0;

    // Directed table: reset, load 3 in idle, run 3/3, zero request,
    // change to 5 during a high phase, reset while a change is pending.
    //   r  en rv rd   clk tk div busy rdy err
    add(0, 0, 0, 0,   0, 0, 1, 0, 1, 0);
    add(1, 0, 1, 3,   0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0,   0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0,   0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0,   0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0,   1, 1, 3, 0, 1, 0);
    add(1, 1, 0, 0,   1, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0,   1, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0,   0, 0, 3, 0, 1, 0);
    add(1, 1, 1, 0,   0, 0, 3, 0, 1, 1);
    add(1, 1, 0, 0,   0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0,   1, 1, 3, 0, 1, 0);
    add(1, 1, 1, 5,   1, 0, 3, 1, 0, 0);
    add(1, 1, 0, 0,   1, 0, 3, 1, 0, 0);
    add(1, 1, 0, 0,   0, 0, 5, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0, 0, 5, 0, 1, 0);
    add(1, 1, 0, 0,   1, 1, 5, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1, 0, 5, 0, 1, 0);
    add(1, 1, 0, 0,   0, 0, 5, 0, 1, 0);
    add(1, 1, 1, 2,   0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0,   0, 0, 1, 0, 1, 0);

    foreach (tbl[i]) begin
      rstn = tbl[i].r; enable = tbl[i].en; req_valid = tbl[i].rv;
      req_div = W'(tbl[i].rd);
      edge_step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_clk, tbl[i].e_tick, tbl[i].e_div,
              tbl[i].e_busy, tbl[i].e_rdy, tbl[i].e_err);
    end

    // Default ratio 1: clk/2 from the second edge after enabling.
    rstn = 1'b0; edge_step();
    rstn = 1'b1; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge_step();
      chk($sformatf("div1.clk_out%0d", i), int'(clk_out), i % 2);
      chk($sformatf("div1.tick%0d", i), int'(tick), i % 2);
    end
    chk("div1.div_cur", int'(div_cur), 1);

    // Disable on the 2nd cycle of a 4-cycle high phase.
    enable = 1'b0; edge_step(); edge_step();
    req_valid = 1'b1; req_div = 4'd4; edge_step();
    req_valid = 1'b0;
    chk("dis.div_cur", int'(div_cur), 4);
    enable = 1'b1;
    cnt = 0;
    while (!tick && cnt < 20) begin edge_step(); cnt++; end
    chk("dis.wait_tick", int'(tick), 1);
    edge_step();
    chk("dis.high2", int'(clk_out), 1);
    enable = 1'b0;
    edge_step(); chk("dis.high3", int'(clk_out), 1);
    edge_step(); chk("dis.high4", int'(clk_out), 1);
    edge_step(); chk("dis.low", int'(clk_out), 0);
    chk("dis.ready", int'(req_ready), 1);
    edge_step(); chk("dis.parked", int'(clk_out), 0);
    chk("dis.busy", int'(busy), 0);

    // Largest ratio: both phases last exactly 15 cycles.
    req_valid = 1'b1; req_div = 4'd15; edge_step();
    req_valid = 1'b0; enable = 1'b1;
    chk("max.div_cur", int'(div_cur), 15);
    cnt = 0;
    while (!tick && cnt < 40) begin edge_step(); cnt++; end
    chk("max.wait_tick", int'(tick), 1);
    cnt = 0;
    while (clk_out && cnt < 40) begin edge_step(); cnt++; end
    chk("max.high_len", cnt, 15);
    cnt = 0;
    while (!clk_out && cnt < 40) begin edge_step(); cnt++; end
    chk("max.low_len", cnt, 15);

    // Pending change with enable dropped while low: applied at once.
    rstn = 1'b0; enable = 1'b0; edge_step();
    rstn = 1'b1; req_valid = 1'b1; req_div = 4'd2; edge_step();
    req_valid = 1'b0; enable = 1'b1; edge_step();
    req_valid = 1'b1; req_div = 4'd3; edge_step();
    req_valid = 1'b0;
    chk("pend.busy", int'(busy), 1);
    chk("pend.ready", int'(req_ready), 0);
    enable = 1'b0; edge_step();
    chk("pend.div_cur", int'(div_cur), 3);
    chk("pend.busy_clr", int'(busy), 0);
    chk("pend.clk_out", int'(clk_out), 0);

    // Random stimulus against the reference model.
    rstn = 1'b0; enable = 1'b0; req_valid = 1'b0; edge_step();
    for (int i = 0; i < 4000; i++) begin
      rstn      = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      req_valid = ($urandom_range(0, 7) == 0);
      req_div   = W'($urandom_range(0, 15));
      edge_step();
      chk_all($sformatf("rnd%0d", i), m_lvl, m_tick, m_div, m_pend, !m_pend, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the width of the divide-ratio field.
REQ-002 The block SHALL have parameter DEF_DIV, default 1, giving the half-period ratio loaded at reset; legal range 1..2^WIDTH-1.
REQ-003 Port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-004 Port rstn, input, 1, reset; synchronous and active-low.
REQ-005 Port enable, input, 1, high to run the divided clock, low to park it low.
REQ-006 Port req_valid, input, 1, a new half-period ratio is offered on req_div.
REQ-007 Port req_div, input, WIDTH, requested half-period ratio in clk cycles.
REQ-008 Port req_ready, output, 1, block can accept a request this cycle.
REQ-009 Port clk_out, output, 1, registered divided clock.
REQ-010 Port tick, output, 1, one-cycle strobe coincident with each clk_out rising transition.
REQ-011 Port div_cur, output, WIDTH, half-period ratio currently in effect.
REQ-012 Port busy, output, 1, a ratio change is pending.
REQ-013 Port err, output, 1, one-cycle strobe when a request with req_div==0 is accepted.

Function
REQ-014 The block SHALL implement states IDLE, RUN and PEND, with internal counter cnt (WIDTH bits, range 1..div_cur) and shadow register shd (WIDTH bits).
REQ-015 IDLE: clk_out=0, cnt=1; when enable=1, next state is RUN with cnt=1 and clk_out still 0.
REQ-016 RUN/PEND: cnt increments each cycle; at terminal count (cnt==div_cur), clk_out toggles and cnt reloads to 1, so each clk_out phase lasts exactly div_cur cycles.
REQ-017 tick SHALL be 1 in exactly the cycles where registered clk_out is 1 and was 0 in the previous cycle.
REQ-018 req_ready SHALL be 1 in IDLE and RUN and 0 in PEND; it is a function of state only.
REQ-019 A request is accepted when req_valid and req_ready are both 1.
REQ-020 An accepted req_div==0 SHALL be discarded: err=1 for one cycle, with no change to state, div_cur or shd.
REQ-021 Accepted nonzero request in IDLE: div_cur <= req_div on the next edge, and the state stays IDLE.
REQ-022 Accepted nonzero request in RUN: shd <= req_div, and the next state is PEND with busy=1.
REQ-023 PEND applies shd only at the terminal count while clk_out=1 (the falling toggle): in that edge, clk_out <= 0, div_cur <= shd and cnt <= 1, then return to RUN, so no clk_out phase is ever shorter than min(old, new) ratio.
REQ-024 A terminal count while clk_out=0 in PEND SHALL toggle normally and keep the change pending.
REQ-025 enable=0 in RUN with clk_out=0: next state is IDLE immediately, cnt=1.
REQ-026 enable=0 in RUN with clk_out=1: the high phase completes to terminal count, then clk_out=0 and the state goes to IDLE.
REQ-027 enable=0 in PEND: at the falling toggle, shd is applied and the state goes to IDLE.
REQ-028 enable=0 in PEND with clk_out=0: shd is applied at once and the state goes to IDLE.
REQ-029 div_cur=1 SHALL yield clk_out = clk/2 (toggles every cycle).
REQ-030 div_cur=2^WIDTH-1 SHALL count without overflow; cnt never exceeds div_cur.
REQ-031 When reset and a request coincide, reset wins and the request is dropped.

Reset
REQ-032 While rstn=0 at a rising clk edge, the block SHALL set: state=IDLE, clk_out=0, tick=0, err=0, busy=0, cnt=1, shd=DEF_DIV, div_cur=DEF_DIV.
REQ-033 req_ready SHALL be 1 in the first cycle after reset release.
REQ-034 Reset asserted mid-operation (any state, any cnt) SHALL take effect at the next edge with no completion of the current phase.

Verification
REQ-035 Reset, DEF_DIV=1, enable=1 -> clk_out toggles every cycle from the 2nd edge; tick every 2nd cycle; div_cur=1.
REQ-036 In IDLE, request 3, then enable=1 -> clk_out high 3 / low 3 cycles; tick period 6 cycles.
REQ-037 In RUN at div 3, request 5 during the high phase -> busy=1 and req_ready=0 until the falling toggle; next high phase is 5 cycles; no phase shorter than 3.
REQ-038 Request 0 -> err pulses 1 cycle; div_cur, state and clk_out waveform unchanged.
REQ-039 enable dropped at the 2nd cycle of a 4-cycle high phase -> clk_out stays high 2 more cycles, then 0; state IDLE; req_ready=1.
REQ-040 rstn=0 during PEND at cnt=2 -> next edge: clk_out=0, busy=0, div_cur=DEF_DIV, pending shd lost.
